cic_decimator: RTL and testbench
================================

CIC_DECIMATOR -- requirements
Module: cic_decimator

Interface
REQ-001 SHALL have parameter W, default 10: input and output sample width, signed two's complement.
REQ-002 SHALL have parameter N, default 3: number of integrator stages and number of comb stages (filter order).
REQ-003 SHALL have parameter RMAX, default 16: maximum decimation ratio, a power of two >= 2.
REQ-004 SHALL have parameter M, default 1: comb differential delay, 1 or 2.
REQ-005 SHALL have parameter CH, default 2: number of time-interleaved channels, >= 1.
REQ-006 SHALL define derived widths: KW = clog2(clog2(RMAX)+1); CW = max(1, clog2(CH)); BW = W + N*(clog2(RMAX)+clog2(M)).
REQ-007 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-009 SHALL have port in_valid, input, 1: in_data/in_ch qualify this cycle.
REQ-010 SHALL have port in_ch, input, CW: channel index of in_data.
REQ-011 SHALL have port in_data, input, W: signed input sample.
REQ-012 SHALL have port rate_log2, input, KW: decimation R = 2^rate_log2; values above clog2(RMAX) are clamped to clog2(RMAX).
REQ-013 SHALL have port out_valid, output, 1: one-cycle strobe per output sample.
REQ-014 SHALL have port out_ch, output, CW: channel index of out_data.
REQ-015 SHALL have port out_data, output, W: signed decimated, gain-normalised sample.
REQ-016 SHALL have port err, output, 1: sticky channel-sequence error flag.

Function
REQ-017 SHALL accept a sample only when in_valid=1 and in_ch equals the expected channel; expected channel starts at 0 and advances 0..CH-1, wrapping to 0.
REQ-018 SHALL drop any in_valid sample whose in_ch differs from the expected channel, leave the expected channel unchanged, and set err=1 until reset.
REQ-019 SHALL sustain one accepted sample per cycle with no backpressure; in_valid gaps of any length are allowed.
REQ-020 SHALL keep independent integrator and comb state per channel per stage; channels SHALL NOT interact.
REQ-021 SHALL sign-extend in_data to BW and perform all integrator and comb arithmetic modulo 2^BW (wrap-around, no saturation).
REQ-022 SHALL define a frame as CH consecutive accepted samples, channel 0 through CH-1.
REQ-023 SHALL use a frame counter 0..R-1, incremented on each accepted channel CH-1 sample and wrapping to 0 after R-1.
REQ-024 SHALL define the decimating frame as the one in which the counter equals R-1; only its samples feed the combs.
REQ-025 SHALL latch rate_log2 only when the frame counter wraps, and at reset; a change mid-frame SHALL take effect from the next frame boundary.
REQ-026 SHALL produce out_data = (comb output) >>> (N*(rate_log2_latched + clog2(M))), arithmetic shift (floor), truncated to the low W bits.
REQ-027 SHALL assert out_valid exactly LAT = 2N+1 cycles after the accepted in_valid cycle of the corresponding decimating sample, with out_ch equal to that sample's channel.
REQ-028 SHALL suppress out_valid for the first N*M decimated outputs of each channel after reset and after every latched change of R; out_ch/out_data are don't-care while out_valid=0.
REQ-029 SHALL, for R=1 and M=1, yield out_data equal to in_data, each output occurring LAT cycles after its input.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, clear all integrator, comb and pipeline state, the frame counter, expected channel, err, out_valid, out_ch and out_data to 0, and latch rate_log2.
REQ-031 SHALL apply reset mid-operation immediately: all in-flight pipeline samples are discarded, and no out_valid occurs until LAT cycles after the first post-reset decimating sample.

Verification
REQ-032 SHALL be verified with defaults: hold rst_n=0 for 2 cycles -> out_valid=0, out_data=0, out_ch=0, err=0.
REQ-033 SHALL be verified with DC input: rate_log2=2 (R=4), ch0=100, ch1=-37 every cycle -> after 3 suppressed outputs per channel, pairs (0,100),(1,-37) every 8 accepted samples, each LAT=7 cycles after the decimating input.
REQ-034 SHALL be verified with ramp input: in_data incrementing by 1 per accepted sample, wrapping at 10 bits, rate_log2=4 -> every out_data matches a bit-true golden CIC model, including across the integrator wrap.
REQ-035 SHALL be verified with a rate change: rate_log2 changed 2->3 mid-frame -> old R holds to the frame boundary, then 3 outputs per channel are suppressed, then outputs arrive at R=8 spacing.
REQ-036 SHALL be verified with a sequence error: in_ch=1 sent when 0 is expected -> sample dropped, err=1 sticky, expected channel still 0; rst_n=0 clears err.
REQ-037 SHALL be verified with reset mid-stream and R=1 bypass: rst_n pulsed between the decimating input and its output -> that output is never produced; then rate_log2=0 -> out_data equals in_data delayed 7 cycles.

Source files
------------

// File: rtl/cic_decimator.sv
// Multi-channel time-interleaved CIC decimator: N integrators, N combs (delay M),
// runtime power-of-two rate, output normalised by the CIC gain R^N * M^N.
module cic_decimator #(
  parameter int W    = 10,
  parameter int N    = 3,
  parameter int RMAX = 16,
  parameter int M    = 1,
  parameter int CH   = 2,
  localparam int LR  = $clog2(RMAX),
  localparam int KW  = $clog2(LR + 1),
  localparam int CW  = (CH > 1) ? $clog2(CH) : 1,
  localparam int BW  = W + N * (LR + $clog2(M))
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [CW-1:0]       in_ch,
  input  logic signed [W-1:0] in_data,
  input  logic [KW-1:0]       rate_log2,
  output logic                out_valid,
  output logic [CW-1:0]       out_ch,
  output logic signed [W-1:0] out_data,
  output logic                err
);
  localparam int LM   = $clog2(M);
  localparam int S    = 2 * N;
  localparam int SUPW = $clog2(N * M + 1);

  logic [CW-1:0]   exp_ch;
  logic [LR-1:0]   frame_cnt;
  logic [LR-1:0]   frame_last;
  logic [KW-1:0]   rate_reg;
  logic [KW-1:0]   rate_in;
  logic            accept;
  logic            chan_last;
  logic            dec_now;
  logic            sup_now;
  logic            rate_change;
  logic [SUPW-1:0] sup_cnt [CH];

  logic [BW-1:0]   integ [N][CH];
  logic [BW-1:0]   dly   [N][CH][M];

  // Stage s reads sin_* and registers into p_*; sin_*[0] is the accepted input.
  logic            sin_valid [S];
  logic            sin_dec   [S];
  logic            sin_keep  [S];
  logic [CW-1:0]   sin_ch    [S];
  logic [KW-1:0]   sin_rate  [S];
  logic [BW-1:0]   sin_data  [S];
  logic            p_valid   [S];
  logic            p_dec     [S];
  logic            p_keep    [S];
  logic [CW-1:0]   p_ch      [S];
  logic [KW-1:0]   p_rate    [S];
  logic [BW-1:0]   p_data    [S];

  logic signed [BW-1:0] shifted;
  int                   shamt;

  always_comb begin
    rate_in     = (rate_log2 > KW'(LR)) ? KW'(LR) : rate_log2;
    frame_last  = LR'((1 << rate_reg) - 1);
    accept      = in_valid && (in_ch == exp_ch);
    chan_last   = (exp_ch == CW'(CH - 1));
    dec_now     = (frame_cnt == frame_last);
    sup_now     = (sup_cnt[exp_ch] < SUPW'(N * M));
    rate_change = (rate_in != rate_reg);

    sin_valid[0] = accept;
    sin_dec[0]   = dec_now;
    sin_keep[0]  = !sup_now;
    sin_ch[0]    = in_ch;
    sin_rate[0]  = rate_reg;
    sin_data[0]  = {{(BW - W){in_data[W-1]}}, in_data};
    for (int s = 1; s < S; s++) begin
      sin_valid[s] = p_valid[s-1];
      sin_dec[s]   = p_dec[s-1];
      sin_keep[s]  = p_keep[s-1];
      sin_ch[s]    = p_ch[s-1];
      sin_rate[s]  = p_rate[s-1];
      sin_data[s]  = p_data[s-1];
    end

    shamt   = N * (int'(p_rate[S-1]) + LM);
    shifted = $signed(p_data[S-1]) >>> shamt;
  end

  // Channel sequencing, frame counting, rate latch and warm-up suppression.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_ch    <= '0;
      frame_cnt <= '0;
      rate_reg  <= rate_in;
      err       <= 1'b0;
      for (int c = 0; c < CH; c++) sup_cnt[c] <= '0;
    end else begin
      if (in_valid && !accept) err <= 1'b1;
      if (accept) begin
        exp_ch <= chan_last ? '0 : exp_ch + 1'b1;
        if (dec_now && sup_now) sup_cnt[exp_ch] <= sup_cnt[exp_ch] + 1'b1;
        if (chan_last) begin
          if (dec_now) begin
            frame_cnt <= '0;
            rate_reg  <= rate_in;
            // Comb history spans the old rate, so restart the warm-up count.
            if (rate_change)
              for (int c = 0; c < CH; c++) sup_cnt[c] <= '0;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < S; s++) begin
        p_valid[s] <= 1'b0;
        p_dec[s]   <= 1'b0;
        p_keep[s]  <= 1'b0;
        p_ch[s]    <= '0;
        p_rate[s]  <= '0;
        p_data[s]  <= '0;
      end
      for (int i = 0; i < N; i++)
        for (int c = 0; c < CH; c++) begin
          integ[i][c] <= '0;
          for (int m = 0; m < M; m++) dly[i][c][m] <= '0;
        end
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else begin
      for (int s = 0; s < S; s++) begin
        p_valid[s] <= sin_valid[s];
        p_dec[s]   <= sin_dec[s];
        p_keep[s]  <= sin_keep[s];
        p_ch[s]    <= sin_ch[s];
        p_rate[s]  <= sin_rate[s];
      end
      for (int i = 0; i < N; i++) begin
        p_data[i] <= integ[i][sin_ch[i]] + sin_data[i];
        if (sin_valid[i])
          integ[i][sin_ch[i]] <= integ[i][sin_ch[i]] + sin_data[i];
      end
      // Combs only advance on samples from the decimating frame.
      for (int j = 0; j < N; j++) begin
        p_data[N+j] <= sin_data[N+j] - dly[j][sin_ch[N+j]][M-1];
        if (sin_valid[N+j] && sin_dec[N+j]) begin
          dly[j][sin_ch[N+j]][0] <= sin_data[N+j];
          for (int m = 1; m < M; m++)
            dly[j][sin_ch[N+j]][m] <= dly[j][sin_ch[N+j]][m-1];
        end
      end
      out_valid <= p_valid[S-1] && p_dec[S-1] && p_keep[S-1];
      out_ch    <= p_ch[S-1];
      out_data  <= shifted[W-1:0];
    end
  end
endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator (defaults W=10 N=3 RMAX=16 M=1 CH=2).
module tb_cic_decimator;
  localparam int W = 10;
  localparam int KW = 3;
  localparam int CW = 1;
  localparam int LAT = 7;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic [CW-1:0]       in_ch = '0;
  logic signed [W-1:0] in_data = '0;
  logic [KW-1:0]       rate_log2 = '0;
  logic                out_valid;
  logic [CW-1:0]       out_ch;
  logic signed [W-1:0] out_data;
  logic                err;

  int checks = 0;
  int fails = 0;
  int ec = 0;
  int obs_cyc[$];
  int obs_ch[$];
  int obs_data[$];

  cic_decimator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch),
    .in_data(in_data), .rate_log2(rate_log2), .out_valid(out_valid),
    .out_ch(out_ch), .out_data(out_data), .err(err)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, take the edge, record any output strobe.
  task automatic step(input logic v, input int ch, input int d);
    in_valid = v;
    in_ch    = ch[CW-1:0];
    in_data  = d[W-1:0];
    @(posedge clk);
    #1;
    ec++;
    if (out_valid) begin
      obs_cyc.push_back(ec);
      obs_ch.push_back(int'(out_ch));
      obs_data.push_back(int'(out_data));
      $display("cycle %0d: out ch=%0d data=%0d", ec, out_ch, out_data);
    end
  endtask

  task automatic restart(input int rl);
    rate_log2 = rl[KW-1:0];
    rst_n = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    rst_n = 1'b1;
    obs_cyc.delete();
    obs_ch.delete();
    obs_data.delete();
  endtask

  task automatic test_reset();
    rate_log2 = 3'd2;
    rst_n = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    checks++; if (out_ch !== '0) begin fails++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    rst_n = 1'b1;
  endtask

  task automatic test_dc();
    int e_cyc[$], e_ch[$], e_data[$];
    restart(2);
    for (int k = 0; k < 64; k++) begin
      int d;
      d = (k % 2 == 0) ? 100 : -37;
      step(1, k % 2, d);
      if ((k / 2) % 4 == 3 && (k / 2) / 4 >= 3) begin
        e_cyc.push_back(ec + LAT - 1); e_ch.push_back(k % 2); e_data.push_back(d);
      end
    end
    repeat (12) step(0, 0, 0);
    checks++;
    if (obs_cyc.size() != e_cyc.size()) begin
      fails++; $display("FAIL dc_count: got %0d outputs want %0d", obs_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] !== e_cyc[i] || obs_ch[i] !== e_ch[i] || obs_data[i] !== e_data[i]) begin
        fails++;
        $display("FAIL dc_out[%0d]: got cyc=%0d ch=%0d data=%0d want cyc=%0d ch=%0d data=%0d",
                 i, obs_cyc[i], obs_ch[i], obs_data[i], e_cyc[i], e_ch[i], e_data[i]);
      end
    end
  endtask

  task automatic test_ramp();
    int e_cyc[$], e_ch[$], e_data[$];
    int h[64], g[64];
    int xh[2][200];
    int nc[2];
    int k, s;
    for (int i = 0; i < 64; i++) h[i] = 0;
    h[0] = 1;
    repeat (3) begin
      for (int i = 0; i < 64; i++) begin
        g[i] = 0;
        for (int j = 0; j < 16; j++) if (i - j >= 0) g[i] += h[i-j];
      end
      h = g;
    end
    nc[0] = 0; nc[1] = 0;
    restart(4);
    k = 0; s = 0;
    while (k < 320) begin
      if (s % 5 == 4) begin
        step(0, 0, 0);
      end else begin
        int vv, ch, n;
        longint acc;
        logic [63:0] acc_bits;
        logic signed [21:0] a22;
        logic signed [21:0] sh22;
        logic signed [9:0] o10;
        vv = (400 + k) & 1023;
        if (vv >= 512) vv -= 1024;
        ch = k % 2;
        n = nc[ch];
        xh[ch][n] = vv;
        nc[ch]++;
        step(1, ch, vv);
        if ((k / 2) % 16 == 15 && (k / 2) / 16 >= 3) begin
          acc = 0;
          for (int j = 0; j < 46; j++) if (n - j >= 0) acc += longint'(h[j]) * longint'(xh[ch][n-j]);
          acc_bits = acc;
          a22 = acc_bits[21:0];
          sh22 = a22 >>> 12;
          o10 = sh22[9:0];
          e_cyc.push_back(ec + LAT - 1); e_ch.push_back(ch); e_data.push_back(int'(o10));
        end
        k++;
      end
      s++;
    end
    repeat (12) step(0, 0, 0);
    checks++;
    if (obs_cyc.size() != e_cyc.size()) begin
      fails++; $display("FAIL ramp_count: got %0d outputs want %0d", obs_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] !== e_cyc[i] || obs_ch[i] !== e_ch[i] || obs_data[i] !== e_data[i]) begin
        fails++;
        $display("FAIL ramp_out[%0d]: got cyc=%0d ch=%0d data=%0d want cyc=%0d ch=%0d data=%0d",
                 i, obs_cyc[i], obs_ch[i], obs_data[i], e_cyc[i], e_ch[i], e_data[i]);
      end
    end
  endtask

  task automatic test_rate_change();
    int e_cyc[$], e_ch[$], e_data[$];
    int kept[10] = '{30, 31, 38, 39, 46, 47, 110, 111, 126, 127};
    restart(2);
    for (int k = 0; k < 128; k++) begin
      int d;
      if (k == 43) rate_log2 = 3'd3;
      d = (k % 2 == 0) ? 100 : -37;
      step(1, k % 2, d);
      foreach (kept[i]) if (kept[i] == k) begin
        e_cyc.push_back(ec + LAT - 1); e_ch.push_back(k % 2); e_data.push_back(d);
      end
    end
    repeat (12) step(0, 0, 0);
    checks++;
    if (obs_cyc.size() != e_cyc.size()) begin
      fails++; $display("FAIL rate_count: got %0d outputs want %0d", obs_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] !== e_cyc[i] || obs_ch[i] !== e_ch[i] || obs_data[i] !== e_data[i]) begin
        fails++;
        $display("FAIL rate_out[%0d]: got cyc=%0d ch=%0d data=%0d want cyc=%0d ch=%0d data=%0d",
                 i, obs_cyc[i], obs_ch[i], obs_data[i], e_cyc[i], e_ch[i], e_data[i]);
      end
    end
  endtask

  task automatic test_seq_error();
    int e_cyc[$], e_ch[$], e_data[$];
    restart(0);
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL seq_err_initial: got %b want 0", err); end
    step(1, 1, 77);
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL seq_err_set: got %b want 1", err); end
    for (int k = 0; k < 12; k++) begin
      int d;
      d = -200 + 37 * k;
      step(1, k % 2, d);
      if (k >= 6) begin
        e_cyc.push_back(ec + LAT - 1); e_ch.push_back(k % 2); e_data.push_back(d);
      end
    end
    repeat (10) step(0, 0, 0);
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL seq_err_sticky: got %b want 1", err); end
    checks++;
    if (obs_cyc.size() != e_cyc.size()) begin
      fails++; $display("FAIL seq_count: got %0d outputs want %0d", obs_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] !== e_cyc[i] || obs_ch[i] !== e_ch[i] || obs_data[i] !== e_data[i]) begin
        fails++;
        $display("FAIL seq_out[%0d]: got cyc=%0d ch=%0d data=%0d want cyc=%0d ch=%0d data=%0d",
                 i, obs_cyc[i], obs_ch[i], obs_data[i], e_cyc[i], e_ch[i], e_data[i]);
      end
    end
    rst_n = 1'b0;
    step(0, 0, 0);
    rst_n = 1'b1;
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL seq_err_cleared: got %b want 0", err); end
  endtask

  task automatic test_reset_midstream();
    int e_cyc[$], e_ch[$], e_data[$];
    restart(2);
    for (int k = 0; k < 32; k++) step(1, k % 2, (k % 2 == 0) ? 100 : -37);
    step(0, 0, 0);
    step(0, 0, 0);
    rate_log2 = 3'd0;
    rst_n = 1'b0;
    step(0, 0, 0);
    rst_n = 1'b1;
    repeat (10) step(0, 0, 0);
    checks++;
    if (obs_cyc.size() != 0) begin
      fails++; $display("FAIL midreset_flushed: got %0d outputs want 0", obs_cyc.size());
    end
    obs_cyc.delete(); obs_ch.delete(); obs_data.delete();
    for (int k = 0; k < 20; k++) begin
      int d;
      d = ((k * 53) % 1000) - 500;
      step(1, k % 2, d);
      if (k >= 6) begin
        e_cyc.push_back(ec + LAT - 1); e_ch.push_back(k % 2); e_data.push_back(d);
      end
    end
    repeat (10) step(0, 0, 0);
    checks++;
    if (obs_cyc.size() != e_cyc.size()) begin
      fails++; $display("FAIL bypass_count: got %0d outputs want %0d", obs_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < e_cyc.size() && i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] !== e_cyc[i] || obs_ch[i] !== e_ch[i] || obs_data[i] !== e_data[i]) begin
        fails++;
        $display("FAIL bypass_out[%0d]: got cyc=%0d ch=%0d data=%0d want cyc=%0d ch=%0d data=%0d",
                 i, obs_cyc[i], obs_ch[i], obs_data[i], e_cyc[i], e_ch[i], e_data[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_ramp();
    test_rate_change();
    test_seq_error();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
